// File: rtl/pulse_counter_mc_param.sv
// ---------------------------------------------------------------------------
// pulse_counter_mc_param
//   Counts pulses on NUM_CH asynchronous channel inputs over a window bounded
//   by rising edges of an asynchronous RTC reference.  When the window closes,
//   all counts are copied into shadow registers and streamed out serially,
//   channel by channel, as LOAD + CNT_W shift cycles per channel.
//   Counters saturate at all-ones and raise a sticky per-channel overflow
//   flag instead of wrapping.  An RTC edge that arrives while a frame is
//   still being sent is not accepted: the window simply keeps growing and
//   ovf_rtc_out records the missed edge.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low clear of all state
//   ch_in        raw pulse inputs (asynchronous)
//   rtc          window reference (asynchronous), rising edge closes window
//   edge_mode    0: count rising edges, 1: count rising and falling edges
//   serial_out   serial count data, MSB first
//   sl_out       high during the LOAD cycle of each channel frame
//   addr_out     channel index of the current / last frame
//   ovf_ch_out   saturation flag of channel addr_out from the snapshot
//   ovf_global   OR of all saturation flags in the last snapshot
//   ovf_rtc_out  sticky: RTC edge arrived while busy
//   busy         high while the serialiser is not idle
// ---------------------------------------------------------------------------
module pulse_counter_mc_param #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 8,
   parameter int ADDR_W      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_in,
   input  logic              rtc,
   input  logic              edge_mode,
   output logic              serial_out,
   output logic              sl_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic              ovf_ch_out,
   output logic              ovf_global,
   output logic              ovf_rtc_out,
   output logic              busy
);

   localparam int                BIT_W   = $clog2(CNT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   // synchronisers and edge-detect history
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] ch_sync_r;
   logic [NUM_CH-1:0]                  ch_prev_r;
   logic [SYNC_STAGES-1:0]             rtc_sync_r;
   logic                               rtc_prev_r;

   // counting
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_r;
   logic [NUM_CH-1:0]            ovf_r;
   logic [NUM_CH-1:0][CNT_W-1:0] shadow_r;
   logic [NUM_CH-1:0]            shadow_ovf_r;

   // serialiser
   state_t            state_r;
   logic [CNT_W-1:0]  shift_r;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic [ADDR_W-1:0] addr_r;
   logic              serial_r;
   logic              sl_r;
   logic              ovf_ch_r;
   logic              ovf_global_r;
   logic              ovf_rtc_r;
   logic              busy_r;

   // combinational helpers
   logic [NUM_CH-1:0] ch_cur_s;
   logic [NUM_CH-1:0] ch_rise_s;
   logic [NUM_CH-1:0] ch_fall_s;
   logic [NUM_CH-1:0] edge_s;
   logic              rtc_rise_s;
   logic              snap_s;
   logic [CNT_W-1:0]  sel_cnt_s;
   logic              sel_ovf_s;

   // Synchronise the asynchronous inputs and keep one cycle of history for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch_sync_r  <= '0;
         ch_prev_r  <= '0;
         rtc_sync_r <= '0;
         rtc_prev_r <= 1'b0;
      end else begin
         ch_sync_r  <= {ch_sync_r[SYNC_STAGES-2:0], ch_in};
         ch_prev_r  <= ch_sync_r[SYNC_STAGES-1];
         rtc_sync_r <= {rtc_sync_r[SYNC_STAGES-2:0], rtc};
         rtc_prev_r <= rtc_sync_r[SYNC_STAGES-1];
      end
   end

   // Per-channel edge events selected by edge_mode
   always_comb begin
      ch_cur_s  = ch_sync_r[SYNC_STAGES-1];
      ch_rise_s = ch_cur_s & ~ch_prev_r;
      ch_fall_s = ~ch_cur_s & ch_prev_r;
      if (edge_mode) begin
         edge_s = ch_rise_s | ch_fall_s;
      end else begin
         edge_s = ch_rise_s;
      end
   end

   assign rtc_rise_s = rtc_sync_r[SYNC_STAGES-1] & ~rtc_prev_r;
   // A window only closes while the serialiser is free; otherwise it extends.
   assign snap_s     = rtc_rise_s && (state_r == ST_IDLE);

   // Shadow read mux for the channel being loaded
   always_comb begin
      sel_cnt_s = shadow_r[0];
      sel_ovf_s = shadow_ovf_r[0];
      for (int i = 1; i < NUM_CH; i++) begin
         if (addr_r == ADDR_W'(i)) begin
            sel_cnt_s = shadow_r[i];
            sel_ovf_s = shadow_ovf_r[i];
         end else begin
            sel_cnt_s = sel_cnt_s;
            sel_ovf_s = sel_ovf_s;
         end
      end
   end

   // Saturating counters; an edge coinciding with the snapshot opens the new window at 1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= '0;
         ovf_r <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (snap_s) begin
               cnt_r[i] <= edge_s[i] ? CNT_W'(1) : CNT_W'(0);
               ovf_r[i] <= 1'b0;
            end else if (edge_s[i]) begin
               if (cnt_r[i] == CNT_MAX) begin
                  ovf_r[i] <= 1'b1;
               end else begin
                  cnt_r[i] <= cnt_r[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Missed-window flag: set by any RTC edge not accepted, cleared by an accepted one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_rtc_r <= 1'b0;
      end else if (snap_s) begin
         ovf_rtc_r <= 1'b0;
      end else if (rtc_rise_s) begin
         ovf_rtc_r <= 1'b1;
      end
   end

   // Snapshot capture and frame serialiser FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         shadow_r     <= '0;
         shadow_ovf_r <= '0;
         ovf_global_r <= 1'b0;
         shift_r      <= '0;
         bit_cnt_r    <= '0;
         addr_r       <= '0;
         serial_r     <= 1'b0;
         sl_r         <= 1'b0;
         ovf_ch_r     <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               serial_r <= 1'b0;
               if (snap_s) begin
                  shadow_r     <= cnt_r;
                  shadow_ovf_r <= ovf_r;
                  ovf_global_r <= |ovf_r;
                  addr_r       <= '0;
                  sl_r         <= 1'b1;
                  busy_r       <= 1'b1;
                  state_r      <= ST_LOAD;
               end else begin
                  sl_r   <= 1'b0;
                  busy_r <= 1'b0;
               end
            end
            ST_LOAD: begin
               // First data bit goes out on the next cycle, so present the MSB now
               serial_r  <= sel_cnt_s[CNT_W-1];
               shift_r   <= {sel_cnt_s[CNT_W-2:0], 1'b0};
               ovf_ch_r  <= sel_ovf_s;
               sl_r      <= 1'b0;
               bit_cnt_r <= '0;
               state_r   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (bit_cnt_r == BIT_W'(CNT_W - 1)) begin
                  serial_r <= 1'b0;
                  if (addr_r == ADDR_W'(NUM_CH - 1)) begin
                     busy_r  <= 1'b0;
                     state_r <= ST_IDLE;
                  end else begin
                     addr_r  <= addr_r + ADDR_W'(1);
                     sl_r    <= 1'b1;
                     state_r <= ST_LOAD;
                  end
               end else begin
                  serial_r  <= shift_r[CNT_W-1];
                  shift_r   <= {shift_r[CNT_W-2:0], 1'b0};
                  bit_cnt_r <= bit_cnt_r + BIT_W'(1);
               end
            end
            default: begin
               serial_r <= 1'b0;
               sl_r     <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign serial_out  = serial_r;
   assign sl_out      = sl_r;
   assign addr_out    = addr_r;
   assign ovf_ch_out  = ovf_ch_r;
   assign ovf_global  = ovf_global_r;
   assign ovf_rtc_out = ovf_rtc_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_pulse_counter_mc_param.sv
// Directed bench for pulse_counter_mc_param with default parameters
// (4 channels, 8-bit counts, 3-bit address, 2 sync stages).
module tb_pulse_counter_mc_param;

   logic       clk;
   logic       reset;
   logic [3:0] ch_in;
   logic       rtc;
   logic       edge_mode;
   logic       serial_out;
   logic       sl_out;
   logic [2:0] addr_out;
   logic       ovf_ch_out;
   logic       ovf_global;
   logic       ovf_rtc_out;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic [7:0] got_val [4];
   logic       got_ovf [4];
   int         busy_cycles;
   int         sl_cnt;
   int         fmt_err;

   pulse_counter_mc_param dut (
      .clk         (clk),
      .reset       (reset),
      .ch_in       (ch_in),
      .rtc         (rtc),
      .edge_mode   (edge_mode),
      .serial_out  (serial_out),
      .sl_out      (sl_out),
      .addr_out    (addr_out),
      .ovf_ch_out  (ovf_ch_out),
      .ovf_global  (ovf_global),
      .ovf_rtc_out (ovf_rtc_out),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic pulse(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ch_in[ch] = 1'b1;
         @(negedge clk);
         @(negedge clk);
         ch_in[ch] = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic rtc_pulse();
      repeat (5) @(negedge clk);
      rtc = 1'b1;
      repeat (2) @(negedge clk);
      rtc = 1'b0;
   endtask

   // Waits for a frame and decodes it: 4 x (LOAD + 8 shift cycles)
   task automatic capture_frame();
      int t;
      int f;
      int p;
      t = 0;
      for (int i = 0; i < 4; i++) begin
         got_val[i] = 8'h00;
         got_ovf[i] = 1'b0;
      end
      busy_cycles = 0;
      sl_cnt      = 0;
      fmt_err     = 0;
      while (busy !== 1'b1 && t < 60) begin
         @(negedge clk);
         t++;
      end
      check("frame_start", {31'd0, busy}, 32'd1);
      while (busy === 1'b1 && busy_cycles < 100) begin
         f = busy_cycles / 9;
         p = busy_cycles % 9;
         if (sl_out === 1'b1) sl_cnt++;
         if (f < 4) begin
            if (p == 0) begin
               if (sl_out !== 1'b1 || serial_out !== 1'b0 || addr_out !== 3'(f)) fmt_err++;
            end else begin
               if (sl_out !== 1'b0) fmt_err++;
               got_val[f] = {got_val[f][6:0], serial_out};
               if (p == 1) got_ovf[f] = ovf_ch_out;
            end
         end else begin
            fmt_err++;
         end
         busy_cycles++;
         @(negedge clk);
      end
      check("busy_len", busy_cycles, 32'd36);
      check("sl_count", sl_cnt, 32'd4);
      check("frame_fmt", fmt_err, 32'd0);
   endtask

   function automatic logic [31:0] all_outs();
      return {23'd0, serial_out, sl_out, addr_out, ovf_ch_out, ovf_global, ovf_rtc_out, busy};
   endfunction

   initial begin
      reset     = 1'b0;
      ch_in     = 4'h0;
      rtc       = 1'b0;
      edge_mode = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", all_outs(), 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset", all_outs(), 32'd0);

      // Basic count
      pulse(0, 3);
      pulse(2, 255);
      pulse(3, 17);
      rtc_pulse();
      capture_frame();
      check("basic_ch0", got_val[0], 32'h03);
      check("basic_ch1", got_val[1], 32'h00);
      check("basic_ch2", got_val[2], 32'hFF);
      check("basic_ch3", got_val[3], 32'h11);
      check("basic_ovf_ch2", {31'd0, got_ovf[2]}, 32'd0);
      check("basic_ovf_global", {31'd0, ovf_global}, 32'd0);
      check("basic_idle_addr", {29'd0, addr_out}, 32'd3);
      check("basic_idle_sl_ser", {30'd0, sl_out, serial_out}, 32'd0);

      // Saturation
      pulse(2, 300);
      rtc_pulse();
      capture_frame();
      check("sat_ch2", got_val[2], 32'hFF);
      check("sat_ovf_flags", {28'd0, got_ovf[3], got_ovf[2], got_ovf[1], got_ovf[0]}, 32'b0100);
      check("sat_ovf_global", {31'd0, ovf_global}, 32'd1);
      pulse(2, 5);
      rtc_pulse();
      capture_frame();
      check("sat_next_ch2", got_val[2], 32'h05);
      check("sat_next_ovf_flags", {28'd0, got_ovf[3], got_ovf[2], got_ovf[1], got_ovf[0]}, 32'd0);
      check("sat_next_ovf_global", {31'd0, ovf_global}, 32'd0);

      // Edge mode
      edge_mode = 1'b1;
      pulse(1, 10);
      rtc_pulse();
      capture_frame();
      check("edge_both_ch1", got_val[1], 32'h14);
      edge_mode = 1'b0;
      pulse(1, 10);
      rtc_pulse();
      capture_frame();
      check("edge_rise_ch1", got_val[1], 32'h0A);

      // Missed window: RTC edge during the frame extends the window
      pulse(0, 4);
      rtc_pulse();
      fork
         capture_frame();
         begin
            pulse(0, 1);
            rtc_pulse();
            pulse(0, 2);
         end
      join
      check("missed_frame_ch0", got_val[0], 32'h04);
      check("missed_flag_set", {31'd0, ovf_rtc_out}, 32'd1);
      rtc_pulse();
      capture_frame();
      check("missed_next_ch0", got_val[0], 32'h03);
      check("missed_flag_clear", {31'd0, ovf_rtc_out}, 32'd0);

      // Channel edge in the same cycle as the snapshot
      pulse(0, 2);
      repeat (5) @(negedge clk);
      rtc      = 1'b1;
      ch_in[0] = 1'b1;
      repeat (2) @(negedge clk);
      rtc      = 1'b0;
      ch_in[0] = 1'b0;
      capture_frame();
      check("simul_old_ch0", got_val[0], 32'h02);
      rtc_pulse();
      capture_frame();
      check("simul_new_ch0", got_val[0], 32'h01);

      // Reset in the middle of a frame
      pulse(3, 7);
      rtc_pulse();
      repeat (6) @(negedge clk);
      check("busy_pre_reset", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("midframe_reset_outs", all_outs(), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_idle", all_outs(), 32'd0);
      pulse(1, 6);
      rtc_pulse();
      capture_frame();
      check("post_reset_ch0", got_val[0], 32'h00);
      check("post_reset_ch1", got_val[1], 32'h06);
      check("post_reset_ch3", got_val[3], 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
